linear_step_generator: RTL and testbench

- Motor-side stage directly downstream of the linear opcode processor.
- On a one-tick trigger, it latches a signed relative move (dx, dy) and emits step/direction pulses for the X and Y stepper drivers.
- Uses an integer Bresenham accumulator, so both axes arrive at the target together along a straight line.
- Reports completion on done; the processor's FSM waits on this signal.

---
 rtl/linear_step_generator.sv | 133 +++++++++++++
 tb/tb_linear_step_generator.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/linear_step_generator.sv
// Bresenham step/direction generator: turns a signed relative move (dx, dy) into
// registered X/Y step pulses so both axes reach the target together.
module linear_step_generator #(
    parameter int POS_WIDTH  = 12,
    parameter int STEP_TICKS = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clk_en,
    input  logic                 trigger,
    input  logic [POS_WIDTH-1:0] dx,
    input  logic [POS_WIDTH-1:0] dy,
    output logic                 step_x,
    output logic                 step_y,
    output logic                 dir_x,
    output logic                 dir_y,
    output logic                 done
);

    localparam int ACC_W = POS_WIDTH + 3;
    localparam int CNT_W = $clog2(STEP_TICKS + 1);

    typedef enum logic [2:0] {IDLE, LOAD, STEP, GAP, FINISH} state_t;

    state_t                          state_reg;
    logic [1:0][POS_WIDTH-1:0]       disp;
    logic [1:0][POS_WIDTH-1:0]       mag_next;
    logic [1:0][POS_WIDTH-1:0]       mag_reg;
    logic [POS_WIDTH-1:0]            major_reg;
    logic [POS_WIDTH-1:0]            minor_reg;
    logic [POS_WIDTH-1:0]            remaining_reg;
    logic                            major_is_x_reg;
    logic signed [ACC_W-1:0]         acc_reg;
    logic signed [ACC_W-1:0]         acc_sum;
    logic signed [ACC_W-1:0]         acc_next;
    logic                            minor_hit;
    logic [CNT_W-1:0]                gap_cnt_reg;
    logic                            step_x_reg;
    logic                            step_y_reg;
    logic                            dir_x_reg;
    logic                            dir_y_reg;
    logic                            load_x_major;
    logic [POS_WIDTH-1:0]            load_major;
    logic [POS_WIDTH-1:0]            load_minor;

    assign disp = {dy, dx};

    // Magnitude of each axis; the most negative input wraps to 2^(POS_WIDTH-1),
    // which is exactly its magnitude when read as unsigned.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_abs
            assign mag_next[gi] = disp[gi][POS_WIDTH-1] ? (~disp[gi] + 1'b1) : disp[gi];
        end
    endgenerate

    always_comb begin
        load_x_major = (mag_reg[0] >= mag_reg[1]);
        load_major   = load_x_major ? mag_reg[0] : mag_reg[1];
        load_minor   = load_x_major ? mag_reg[1] : mag_reg[0];
        acc_sum      = acc_reg + $signed({2'b00, minor_reg, 1'b0});
        minor_hit    = (acc_sum >= $signed({3'b000, major_reg}));
        acc_next     = minor_hit ? (acc_sum - $signed({2'b00, major_reg, 1'b0})) : acc_sum;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            mag_reg        <= '0;
            major_reg      <= '0;
            minor_reg      <= '0;
            remaining_reg  <= '0;
            major_is_x_reg <= 1'b0;
            acc_reg        <= '0;
            gap_cnt_reg    <= '0;
            step_x_reg     <= 1'b0;
            step_y_reg     <= 1'b0;
            dir_x_reg      <= 1'b0;
            dir_y_reg      <= 1'b0;
        end else if (clk_en) begin
            case (state_reg)
                IDLE: begin
                    step_x_reg <= 1'b0;
                    step_y_reg <= 1'b0;
                    if (trigger) begin
                        mag_reg   <= mag_next;
                        dir_x_reg <= dx[POS_WIDTH-1];
                        dir_y_reg <= dy[POS_WIDTH-1];
                        state_reg <= LOAD;
                    end
                end
                LOAD: begin
                    major_reg      <= load_major;
                    minor_reg      <= load_minor;
                    major_is_x_reg <= load_x_major;
                    remaining_reg  <= load_major;
                    acc_reg        <= '0;
                    state_reg      <= (load_major == '0) ? FINISH : STEP;
                end
                STEP: begin
                    // Major axis always steps; minor axis steps when the error term crosses.
                    step_x_reg    <= major_is_x_reg ? 1'b1 : minor_hit;
                    step_y_reg    <= major_is_x_reg ? minor_hit : 1'b1;
                    acc_reg       <= acc_next;
                    remaining_reg <= remaining_reg - 1'b1;
                    gap_cnt_reg   <= CNT_W'(STEP_TICKS - 1);
                    state_reg     <= GAP;
                end
                GAP: begin
                    step_x_reg <= 1'b0;
                    step_y_reg <= 1'b0;
                    if (gap_cnt_reg <= CNT_W'(1)) begin
                        state_reg <= (remaining_reg != '0) ? STEP : FINISH;
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg - 1'b1;
                    end
                end
                FINISH: begin
                    step_x_reg <= 1'b0;
                    step_y_reg <= 1'b0;
                    state_reg  <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign step_x = step_x_reg;
    assign step_y = step_y_reg;
    assign dir_x  = dir_x_reg;
    assign dir_y  = dir_y_reg;
    assign done   = (state_reg == IDLE);

endmodule

// File: tb/tb_linear_step_generator.sv
// Scoreboard bench for linear_step_generator: each move pushes its expected
// pulse counts, direction and duration; a monitor pops and compares when done returns.
module tb_linear_step_generator;

    localparam int PW = 12;
    localparam int ST = 4;
    localparam int TIMEOUT = 30000;

    logic          clk = 1'b0;
    logic          reset;
    logic          clk_en;
    logic          trigger;
    logic [PW-1:0] dx;
    logic [PW-1:0] dy;
    logic          step_x, step_y, dir_x, dir_y, done;

    linear_step_generator #(.POS_WIDTH(PW), .STEP_TICKS(ST)) dut (
        .clk(clk), .reset(reset), .clk_en(clk_en), .trigger(trigger),
        .dx(dx), .dy(dy), .step_x(step_x), .step_y(step_y),
        .dir_x(dir_x), .dir_y(dir_y), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int nx;
        int ny;
        bit dxn;
        bit dyn;
        int busy;
        int xhigh;
        int yhigh;
        bit mask_v;
        int mask;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_moves  = 0;
    int   en_period = 1;
    int   cyc = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Enable pattern: changed 2 time units after each edge, applies to the next edge.
    initial begin
        clk_en = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            cyc++;
            clk_en = ((cyc % en_period) == 0);
        end
    end

    // Monitor: values sampled at negedge; prev_* describe the edge that just passed.
    bit prev_en = 0, prev_done = 1, prev_trig = 0;
    bit in_flight = 0, last_sx = 0, last_sy = 0, cap_dx = 0, cap_dy = 0, dir_bad = 0;
    int busy = 0, xc = 0, yc = 0, xhigh = 0, yhigh = 0, slot = 0, ymask = 0, tot_x = 0;

    always @(negedge clk) begin
        if (reset) begin
            in_flight = 0;
            prev_en   = 0;
            prev_trig = 0;
        end else begin
            if (prev_en && prev_done && prev_trig) begin
                in_flight = 1;
                busy = 0; xc = 0; yc = 0; xhigh = 0; yhigh = 0; slot = 0; ymask = 0;
                cap_dx = dir_x; cap_dy = dir_y; dir_bad = 0;
            end else if (in_flight && prev_en && !prev_done) begin
                busy++;
            end
            if (in_flight) begin
                if ((step_x && !last_sx) || (step_y && !last_sy)) slot++;
                if (step_x && !last_sx) xc++;
                if (step_y && !last_sy) begin
                    yc++;
                    if (slot >= 1 && slot <= 31) ymask |= (1 << (slot - 1));
                end
                if (step_x) xhigh++;
                if (step_y) yhigh++;
                if (dir_x !== cap_dx || dir_y !== cap_dy) dir_bad = 1;
            end
            if (in_flight && !prev_done && done) begin
                in_flight = 0;
                n_moves++;
                if (sb.size() == 0) begin
                    check("sb_unexpected_move", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    $display("move %0d: x_pulses=%0d y_pulses=%0d dir=%0d/%0d busy_ticks=%0d ymask=%0h",
                             n_moves, xc, yc, cap_dx, cap_dy, busy, ymask);
                    check("x_pulses", xc, e.nx);
                    check("y_pulses", yc, e.ny);
                    check("dir_x", cap_dx, e.dxn);
                    check("dir_y", cap_dy, e.dyn);
                    check("dir_stable", dir_bad, 0);
                    check("busy_ticks", busy, e.busy);
                    check("x_high_cycles", xhigh, e.xhigh);
                    check("y_high_cycles", yhigh, e.yhigh);
                    if (e.mask_v) check("y_slot_mask", ymask, e.mask);
                end
            end
        end
        if (step_x && !last_sx) tot_x++;
        last_sx   = step_x;
        last_sy   = step_y;
        prev_en   = clk_en;
        prev_done = done;
        prev_trig = trigger;
    end

    task automatic wait_idle_en();
        bit ok = 0;
        for (int i = 0; i < TIMEOUT && !ok; i++) begin
            @(posedge clk);
            #3;
            if (done && clk_en) ok = 1;
        end
        if (!ok) check("timeout_idle", 0, 1);
    endtask

    task automatic wait_tot_x(input int target);
        bit ok = 0;
        for (int i = 0; i < TIMEOUT && !ok; i++) begin
            @(posedge clk);
            #3;
            if (tot_x >= target) ok = 1;
        end
        if (!ok) check("timeout_pulses", tot_x, target);
    endtask

    task automatic do_move(input int mdx, input int mdy, input bit push,
                           input bit mask_v, input int mask);
        exp_t e;
        int ax, ay, major;
        logic [PW-1:0] vx, vy;
        ax = (mdx < 0) ? -mdx : mdx;
        ay = (mdy < 0) ? -mdy : mdy;
        major = (ax > ay) ? ax : ay;
        e.nx = ax; e.ny = ay;
        e.dxn = (mdx < 0); e.dyn = (mdy < 0);
        e.busy = 2 + major * ST;
        e.xhigh = ax * en_period;
        e.yhigh = ay * en_period;
        e.mask_v = mask_v; e.mask = mask;
        wait_idle_en();
        vx = mdx[PW-1:0];
        vy = mdy[PW-1:0];
        dx = vx;
        dy = vy;
        trigger = 1'b1;
        if (push) sb.push_back(e);
        @(posedge clk);
        #3;
        trigger = 1'b0;
    endtask

    initial begin
        int base;
        reset = 1'b1; trigger = 1'b0; dx = '0; dy = '0;
        repeat (3) @(posedge clk);
        #3;
        check("reset_done", done, 1);
        check("reset_step_x", step_x, 0);
        check("reset_step_y", step_y, 0);
        check("reset_dir_x", dir_x, 0);
        check("reset_dir_y", dir_y, 0);
        reset = 1'b0;

        // Back-to-back moves: each trigger lands on the first IDLE tick.
        do_move(4, 2, 1, 1, 'b0101);
        do_move(-3, 1, 1, 1, 'b010);
        do_move(0, 0, 1, 1, 0);
        wait_idle_en();

        en_period = 3;
        do_move(5, -5, 1, 1, 'b11111);
        wait_idle_en();
        en_period = 1;
        wait_idle_en();

        // Abort: second trigger mid-move is ignored, reset stops pulses at once.
        base = tot_x;
        do_move(6, 0, 0, 0, 0);
        wait_tot_x(base + 1);
        dx = 12'd1; dy = 12'd0; trigger = 1'b1;
        @(posedge clk);
        #3;
        trigger = 1'b0;
        wait_tot_x(base + 3);
        reset = 1'b1;
        @(posedge clk);
        #3;
        reset = 1'b0;
        check("abort_done", done, 1);
        check("abort_step_x", step_x, 0);
        check("abort_dir_x", dir_x, 0);
        repeat (60) @(posedge clk);
        #3;
        check("abort_no_more_pulses", tot_x - base, 3);
        check("abort_idle", done, 1);

        do_move(-2048, 1, 1, 0, 0);
        wait_idle_en();
        repeat (4) @(posedge clk);
        check("scoreboard_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
